// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state type, forward S-box, Rcon and GF(2^8) helpers.
package aes_pkg;

   // Number of rounds for a 256-bit key.
   localparam logic [3:0] NR = 4'd14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } aes_fsm_e;

   // Forward S-box, indexed by input byte.
   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Round constants; entry i is Rcon[i] (entry 0 is never used).
   localparam logic [7:0] RCON [8] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by {03} in GF(2^8).
   function automatic logic [7:0] gf_mul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_enc_round
   import aes_pkg::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         last_round,
   output logic [127:0] state_out
);

   // Byte n lives at bits 127-8n; state row r, column c is byte r + 4c.
   logic [7:0] sb [16];
   logic [7:0] sr [16];
   logic [7:0] mc [16];

   genvar gi;

   generate
      for (gi = 0; gi < 16; gi++) begin : g_sub
         assign sb[gi] = sbox(state_in[127-8*gi -: 8]);
      end

      // Row r is rotated left by r columns.
      for (gi = 0; gi < 16; gi++) begin : g_shift
         localparam int R = gi % 4;
         localparam int C = gi / 4;
         assign sr[gi] = sb[R + 4*((C + R) % 4)];
      end

      for (gi = 0; gi < 4; gi++) begin : g_mix
         logic [7:0] a0, a1, a2, a3;
         assign a0 = sr[4*gi];
         assign a1 = sr[4*gi+1];
         assign a2 = sr[4*gi+2];
         assign a3 = sr[4*gi+3];
         assign mc[4*gi]   = xtime(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
         assign mc[4*gi+1] = a0 ^ xtime(a1) ^ gf_mul3(a2) ^ a3;
         assign mc[4*gi+2] = a0 ^ a1 ^ xtime(a2) ^ gf_mul3(a3);
         assign mc[4*gi+3] = gf_mul3(a0) ^ a1 ^ a2 ^ xtime(a3);
      end

      // The final round skips MixColumns.
      for (gi = 0; gi < 16; gi++) begin : g_ark
         assign state_out[127-8*gi -: 8] = (last_round ? sr[gi] : mc[gi]) ^ round_key[127-8*gi -: 8];
      end
   endgenerate

endmodule

// File: rtl/aes_encrypt_256_iter.sv
// Iterative AES-256 encryption core: one round per clock, round keys derived on the fly
// from an 8-word sliding window of the key schedule.
module aes_encrypt_256_iter
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plain,
   input  logic [255:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] cipher,
   output logic         busy
);

   aes_fsm_e     fsm_q, fsm_d;
   logic [127:0] data_q, data_d;
   logic [255:0] win_q, win_d;       // bits 255:224 = w[4r-8] ... bits 31:0 = w[4r-1]
   logic [3:0]   ctr_q, ctr_d;
   logic         in_ready_q, in_ready_d;
   logic         out_valid_q, out_valid_d;
   logic         busy_q, busy_d;

   logic         even_round;
   logic [31:0]  sw_in;
   logic [31:0]  temp_w;
   logic [31:0]  new_w [4];
   logic [127:0] round_key;
   logic [127:0] round_out;

   // Next four key-schedule words from the window; round 1 uses the window's low half directly.
   always_comb begin
      even_round = ~ctr_q[0];
      sw_in      = even_round ? {win_q[23:0], win_q[31:24]} : win_q[31:0];
      temp_w     = sub_word(sw_in) ^ (even_round ? {RCON[ctr_q[3:1]], 24'h000000} : 32'h00000000);
      new_w[0]   = win_q[255:224] ^ temp_w;
      new_w[1]   = win_q[223:192] ^ new_w[0];
      new_w[2]   = win_q[191:160] ^ new_w[1];
      new_w[3]   = win_q[159:128] ^ new_w[2];
      round_key  = (ctr_q == 4'd1) ? win_q[127:0] : {new_w[0], new_w[1], new_w[2], new_w[3]};
   end

   aes_enc_round u_round (
      .state_in   (data_q),
      .round_key  (round_key),
      .last_round (ctr_q == NR),
      .state_out  (round_out)
   );

   // Control FSM and datapath next-state: accept in IDLE, one round per cycle in RUN, hold in DONE.
   always_comb begin
      fsm_d       = fsm_q;
      data_d      = data_q;
      win_d       = win_q;
      ctr_d       = ctr_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      unique case (fsm_q)
         ST_IDLE: begin
            if (in_valid) begin
               data_d     = plain ^ key[255:128];
               win_d      = key;
               ctr_d      = 4'd1;
               fsm_d      = ST_RUN;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         ST_RUN: begin
            data_d = round_out;
            if (ctr_q != 4'd1) begin
               win_d = {win_q[127:0], new_w[0], new_w[1], new_w[2], new_w[3]};
            end
            if (ctr_q == NR) begin
               fsm_d       = ST_DONE;
               out_valid_d = 1'b1;
            end else begin
               ctr_d = ctr_q + 4'd1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               fsm_d       = ST_IDLE;
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            fsm_d       = ST_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // State registers with asynchronous clear; handshake outputs are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= ST_IDLE;
         data_q      <= '0;
         win_q       <= '0;
         ctr_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         data_q      <= data_d;
         win_q       <= win_d;
         ctr_q       <= ctr_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign cipher    = data_q;

endmodule

// File: tb/tb_aes_encrypt_256_iter.sv
// Self-checking bench for aes_encrypt_256_iter: directed FIPS-197 vectors, scoreboard + monitor.
module tb_aes_encrypt_256_iter;

   localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT_C3   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] CT_ZERO = 128'hdc95c078a2408989ad48a21492842087;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] plain = '0;
   logic [255:0] key = '0;
   logic         in_ready;
   logic         out_valid;
   logic         busy;
   logic [127:0] cipher;

   int           errors = 0;
   int           checks = 0;
   logic [127:0] exp_q [$];

   always #5 clk = ~clk;

   aes_encrypt_256_iter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .plain     (plain),
      .key       (key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cipher    (cipher),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Monitor: on every output handshake pop the oldest expected cipher and compare.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got cipher %h with no block outstanding", cipher);
            end else begin
               chk("cipher", cipher, exp_q.pop_front());
            end
         end
      end
   end

   // Present one block at a negedge, push its expected result, return just after the accept edge.
   task automatic issue(input logic [127:0] p, input logic [255:0] k, input logic [127:0] exp);
      @(negedge clk);
      plain    = p;
      key      = k;
      in_valid = 1'b1;
      chk("in_ready_before_accept", 128'(in_ready), 128'd1);
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Called just after an accept edge; counts edges (accept = 1) until out_valid, returns at that negedge.
   task automatic wait_out(input bit scramble, output int lat);
      bit seen;
      seen = 1'b0;
      lat  = 1;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (i == 0) begin
            chk("busy_in_run", 128'(busy), 128'd1);
            chk("in_ready_in_run", 128'(in_ready), 128'd0);
         end
         if (out_valid) begin
            seen = 1'b1;
         end else begin
            if (scramble) begin
               in_valid = ~in_valid;
               plain    = {$urandom, $urandom, $urandom, $urandom};
               key      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk);
            lat++;
         end
      end
      if (scramble) in_valid = 1'b0;
      chk("latency_edges", 128'(lat), 128'd15);
   endtask

   task automatic check_idle_after_handshake();
      @(negedge clk);
      chk("idle_out_valid", 128'(out_valid), 128'd0);
      chk("idle_in_ready", 128'(in_ready), 128'd1);
   endtask

   initial begin
      int lat;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_cipher", cipher, 128'd0);
      chk("rst_in_ready", 128'(in_ready), 128'd1);

      // C.3 accepted on the very first edge after reset release
      rst_n     = 1'b1;
      out_ready = 1'b1;
      plain     = PT_C3;
      key       = KEY_C3;
      in_valid  = 1'b1;
      exp_q.push_back(CT_C3);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_out(1'b0, lat);
      @(posedge clk);
      check_idle_after_handshake();

      // Zero key, zero plaintext
      issue(128'd0, 256'd0, CT_ZERO);
      wait_out(1'b0, lat);
      @(posedge clk);
      check_idle_after_handshake();

      // Back-pressure: hold DONE for 20 cycles while in_valid pulses
      out_ready = 1'b0;
      issue(PT_C3, KEY_C3, CT_C3);
      wait_out(1'b0, lat);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("hold_out_valid", 128'(out_valid), 128'd1);
         chk("hold_cipher", cipher, CT_C3);
         chk("hold_in_ready", 128'(in_ready), 128'd0);
         in_valid = (i % 2 == 0);
         plain    = {$urandom, $urandom, $urandom, $urandom};
         key      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check_idle_after_handshake();

      // Inputs scrambled and in_valid toggling during RUN must not disturb the block
      issue(PT_C3, KEY_C3, CT_C3);
      wait_out(1'b1, lat);
      @(posedge clk);
      check_idle_after_handshake();

      // Reset at round 7 abandons the block
      issue(PT_C3, KEY_C3, CT_C3);
      repeat (6) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 128'(out_valid), 128'd0);
      chk("midrst_busy", 128'(busy), 128'd0);
      chk("midrst_cipher", cipher, 128'd0);
      exp_q.delete();
      repeat (3) begin
         @(negedge clk);
         chk("inrst_out_valid", 128'(out_valid), 128'd0);
      end
      rst_n = 1'b1;
      #1;
      chk("postrst_in_ready", 128'(in_ready), 128'd1);
      issue(128'd0, 256'd0, CT_ZERO);
      wait_out(1'b0, lat);
      @(posedge clk);
      check_idle_after_handshake();

      // Back-to-back: C.3 then zero vector, in_valid held, out_ready constant 1
      @(negedge clk);
      plain    = PT_C3;
      key      = KEY_C3;
      in_valid = 1'b1;
      chk("b2b_in_ready", 128'(in_ready), 128'd1);
      exp_q.push_back(CT_C3);
      @(posedge clk);
      #1;
      plain = 128'd0;
      key   = 256'd0;
      wait_out(1'b0, lat);
      exp_q.push_back(CT_ZERO);
      @(posedge clk);
      @(negedge clk);
      chk("b2b_gap_in_ready", 128'(in_ready), 128'd1);
      chk("b2b_gap_busy", 128'(busy), 128'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_out(1'b0, lat);
      @(posedge clk);
      check_idle_after_handshake();

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/aes_encrypt_256_iter.md
AES_ENCRYPT_256_ITER -- requirements
Module: aes_encrypt_256_iter

Interface
REQ-001 SHALL run on one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  plain/key presented this cycle.
REQ-005 in_ready  output  1  core can accept a block; high only in IDLE.
REQ-006 plain  input  128  plaintext block, bit 127 = byte 0 (FIPS-197 order).
REQ-007 key  input  256  user key, bits 255:128 = round key 0, bits 127:0 = round key 1.
REQ-008 out_valid  output  1  cipher holds a finished block.
REQ-009 out_ready  input  1  downstream accepts cipher this cycle.
REQ-010 cipher  output  128  ciphertext, same byte order as plain.
REQ-011 busy  output  1  high in RUN or DONE.

Function
REQ-012 SHALL implement FIPS-197 AES-256 encryption, Nr = 14, one round per clock, round keys generated on the fly; no full key expansion stored.
REQ-013 States: IDLE, RUN, DONE; encoded as the package enum.
REQ-014 IDLE: in_ready=1; on in_valid at an edge SHALL load state <= plain ^ key[255:128], key window <= key, round counter <= 1, go RUN.
REQ-015 plain and key SHALL be sampled only on the accept edge; later changes have no effect on the block in flight.
REQ-016 RUN: each edge SHALL apply round r = counter: SubBytes, ShiftRows, MixColumns (omitted when r = 14), AddRoundKey with round key r.
REQ-017 Round key 1 = window bits 127:0; for r >= 2 SHALL derive 4 new words from the 8-word window: temp = SubWord(RotWord(w[4r-1])) ^ Rcon[r/2] when r even, SubWord(w[4r-1]) when r odd; w[4r] = w[4r-8] ^ temp; w[4r+k] = w[4r+k-8] ^ w[4r+k-1], k = 1..3; window then shifts by 4 words.
REQ-018 Counter 4 bits, increments 1..14; at r = 14 edge SHALL go DONE; counter never wraps past 14.
REQ-019 Latency: out_valid rises exactly 15 edges after the accept edge (accept edge counted as the first).
REQ-020 DONE: out_valid=1, cipher stable; SHALL hold indefinitely while out_ready=0.
REQ-021 DONE with out_ready=1 at an edge SHALL return to IDLE; out_valid low next cycle; new block accepted no earlier than the following edge (throughput 1 block / 16 cycles minimum).
REQ-022 in_valid while in RUN or DONE SHALL be ignored (in_ready=0, no state change).
REQ-023 cipher SHALL read the state register only; it is 0 when out_valid=0 is not required, but it SHALL not change while out_valid=1.
REQ-024 out_ready while not DONE SHALL have no effect.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, state=0, key window=0, counter=0, in_ready=1 after release, out_valid=0, busy=0, cipher=0.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abandon the block; no out_valid for it after release.
REQ-027 First accept SHALL be possible on the first edge after rst_n deasserts.

Structure
REQ-028 Shared package aes_pkg SHALL hold: forward S-box function/table, Rcon table, NR=14 constant, state enum type, xtime/GF multiply helpers.
REQ-029 One sub-module aes_enc_round: combinational SubBytes/ShiftRows/optional MixColumns/AddRoundKey, input last_round selects MixColumns bypass.
REQ-030 Key-word generation SHALL be in the top module, sharing the package S-box.

Verification
REQ-031 FIPS-197 C.3: key 000102...1e1f, plain 00112233445566778899aabbccddeeff -> cipher 8ea2b7ca516745bfeafc49904b496089, out_valid 15 edges after accept.
REQ-032 Zero key, zero plain -> cipher dc95c078a2408989ad48a21492842087.
REQ-033 out_ready held 0 for 20 cycles after out_valid -> cipher and out_valid stable throughout; in_valid pulses ignored; release out_ready -> IDLE next cycle.
REQ-034 Change plain/key and toggle in_valid every cycle during RUN -> C.3 result unchanged.
REQ-035 rst_n low at round 7 of C.3 -> outputs 0 immediately; after release, zero-vector block completes correctly with no stale out_valid.
REQ-036 Back-to-back: C.3 then zero vector with out_ready=1 constant -> two correct ciphers, second accept exactly 1 edge after first completes.
